// File: rtl/morra_scoreboard.sv
// Morra scoreboard: round and game tallies plus an 8-entry round-history FIFO,
// tracking the game FSMD through its INIZIA/MANCHE/PARTITA outputs.
module morra_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       INIZIA,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  input  logic       RD_EN,
  output logic [3:0] P1_ROUNDS,
  output logic [3:0] P2_ROUNDS,
  output logic [3:0] DRAWS,
  output logic [7:0] P1_GAMES,
  output logic [7:0] P2_GAMES,
  output logic [7:0] TIE_GAMES,
  output logic       GAME_OVER,
  output logic [1:0] HIST_DATA,
  output logic [3:0] HIST_COUNT,
  output logic       HIST_EMPTY,
  output logic       HIST_FULL,
  output logic       HIST_OVF
);

  typedef enum logic [1:0] {StIdle, StPlaying, StEnded} state_e;

  state_e state_q, state_d;
  logic   game_over_q, game_over_d;

  logic [3:0] p1_rounds_q, p1_rounds_d;
  logic [3:0] p2_rounds_q, p2_rounds_d;
  logic [3:0] draws_q, draws_d;
  logic [7:0] p1_games_q, p1_games_d;
  logic [7:0] p2_games_q, p2_games_d;
  logic [7:0] tie_games_q, tie_games_d;

  logic [1:0] mem_q [8];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  logic playing;
  logic push;
  logic pop;
  logic push_ok;
  logic full;

  // Round activity only counts while a game is live and no restart is pending.
  assign playing = (state_q == StPlaying) && !INIZIA;
  assign full    = (count_q == 4'd8);
  assign push    = playing && (MANCHE != 2'b00);
  assign pop     = !INIZIA && RD_EN && (count_q != 4'd0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push && (!full || pop);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (INIZIA) begin
      state_d = StPlaying;
    end else if ((state_q == StPlaying) && (PARTITA != 2'b00)) begin
      state_d = StEnded;
    end
  end

  // Output decode: registered so GAME_OVER tracks state_q exactly
  always_comb begin
    game_over_d = (state_d == StEnded);
  end

  // Tally next-state with saturation
  always_comb begin
    p1_rounds_d = p1_rounds_q;
    p2_rounds_d = p2_rounds_q;
    draws_d     = draws_q;
    p1_games_d  = p1_games_q;
    p2_games_d  = p2_games_q;
    tie_games_d = tie_games_q;
    if (INIZIA) begin
      p1_rounds_d = 4'd0;
      p2_rounds_d = 4'd0;
      draws_d     = 4'd0;
    end else if (playing) begin
      unique case (MANCHE)
        2'b01:   if (p1_rounds_q != 4'hF) p1_rounds_d = p1_rounds_q + 4'd1;
        2'b10:   if (p2_rounds_q != 4'hF) p2_rounds_d = p2_rounds_q + 4'd1;
        2'b11:   if (draws_q != 4'hF) draws_d = draws_q + 4'd1;
        default: ;
      endcase
      unique case (PARTITA)
        2'b01:   if (p1_games_q != 8'hFF) p1_games_d = p1_games_q + 8'd1;
        2'b10:   if (p2_games_q != 8'hFF) p2_games_d = p2_games_q + 8'd1;
        2'b11:   if (tie_games_q != 8'hFF) tie_games_d = tie_games_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Tally registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_rounds_q <= 4'd0;
      p2_rounds_q <= 4'd0;
      draws_q     <= 4'd0;
      p1_games_q  <= 8'd0;
      p2_games_q  <= 8'd0;
      tie_games_q <= 8'd0;
    end else begin
      p1_rounds_q <= p1_rounds_d;
      p2_rounds_q <= p2_rounds_d;
      draws_q     <= draws_d;
      p1_games_q  <= p1_games_d;
      p2_games_q  <= p2_games_d;
      tie_games_q <= tie_games_d;
    end
  end

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (INIZIA) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 3'd1;
      if (pop)     rd_ptr_d = rd_ptr_q + 3'd1;
      if (push && !push_ok) ovf_d = 1'b1;
      if (push_ok && !pop) begin
        count_d = count_q + 4'd1;
      end else if (pop && !push_ok) begin
        count_d = count_q - 4'd1;
      end
    end
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since HIST_DATA is masked when empty
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= MANCHE;
    end
  end

  assign P1_ROUNDS  = p1_rounds_q;
  assign P2_ROUNDS  = p2_rounds_q;
  assign DRAWS      = draws_q;
  assign P1_GAMES   = p1_games_q;
  assign P2_GAMES   = p2_games_q;
  assign TIE_GAMES  = tie_games_q;
  assign GAME_OVER  = game_over_q;
  assign HIST_COUNT = count_q;
  assign HIST_EMPTY = (count_q == 4'd0);
  assign HIST_FULL  = full;
  assign HIST_OVF   = ovf_q;
  assign HIST_DATA  = (count_q == 4'd0) ? 2'b00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_morra_scoreboard.sv
// Self-checking bench for morra_scoreboard: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_morra_scoreboard;

  logic       clk;
  logic       rst;
  logic       INIZIA;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;
  logic       RD_EN;
  logic [3:0] P1_ROUNDS, P2_ROUNDS, DRAWS;
  logic [7:0] P1_GAMES, P2_GAMES, TIE_GAMES;
  logic       GAME_OVER;
  logic [1:0] HIST_DATA;
  logic [3:0] HIST_COUNT;
  logic       HIST_EMPTY, HIST_FULL, HIST_OVF;

  morra_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .INIZIA     (INIZIA),
    .MANCHE     (MANCHE),
    .PARTITA    (PARTITA),
    .RD_EN      (RD_EN),
    .P1_ROUNDS  (P1_ROUNDS),
    .P2_ROUNDS  (P2_ROUNDS),
    .DRAWS      (DRAWS),
    .P1_GAMES   (P1_GAMES),
    .P2_GAMES   (P2_GAMES),
    .TIE_GAMES  (TIE_GAMES),
    .GAME_OVER  (GAME_OVER),
    .HIST_DATA  (HIST_DATA),
    .HIST_COUNT (HIST_COUNT),
    .HIST_EMPTY (HIST_EMPTY),
    .HIST_FULL  (HIST_FULL),
    .HIST_OVF   (HIST_OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model: 0 idle, 1 playing, 2 ended
  int m_state;
  int m_rounds [3];  // p1, p2, draws
  int m_games  [3];  // p1, p2, ties
  int m_hist [$];
  int m_ovf;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic i, input logic [1:0] m,
                            input logic [1:0] p, input logic rd);
    if (r) begin
      m_state = 0;
      foreach (m_rounds[k]) m_rounds[k] = 0;
      foreach (m_games[k])  m_games[k] = 0;
      m_hist.delete();
      m_ovf = 0;
    end else if (i) begin
      m_state = 1;
      foreach (m_rounds[k]) m_rounds[k] = 0;
      m_hist.delete();
      m_ovf = 0;
    end else begin
      if (rd && m_hist.size() > 0) void'(m_hist.pop_front());
      if (m_state == 1) begin
        if (m != 0) begin
          if (m_hist.size() < 8) m_hist.push_back(int'(m));
          else m_ovf = 1;
          m_rounds[m - 1] = (m_rounds[m - 1] < 15) ? m_rounds[m - 1] + 1 : 15;
        end
        if (p != 0) begin
          m_games[p - 1] = (m_games[p - 1] < 255) ? m_games[p - 1] + 1 : 255;
          m_state = 2;
        end
      end
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = m_hist.size();
    check("p1_rounds", int'(P1_ROUNDS), m_rounds[0]);
    check("p2_rounds", int'(P2_ROUNDS), m_rounds[1]);
    check("draws", int'(DRAWS), m_rounds[2]);
    check("p1_games", int'(P1_GAMES), m_games[0]);
    check("p2_games", int'(P2_GAMES), m_games[1]);
    check("tie_games", int'(TIE_GAMES), m_games[2]);
    check("game_over", int'(GAME_OVER), (m_state == 2) ? 1 : 0);
    check("hist_count", int'(HIST_COUNT), sz);
    check("hist_data", int'(HIST_DATA), (sz > 0) ? m_hist[0] : 0);
    check("hist_empty", int'(HIST_EMPTY), (sz == 0) ? 1 : 0);
    check("hist_full", int'(HIST_FULL), (sz == 8) ? 1 : 0);
    check("hist_ovf", int'(HIST_OVF), m_ovf);
  endtask

  // Apply one cycle of inputs, advance the model with the same edge, then compare.
  task automatic step(input logic r, input logic i, input logic [1:0] m,
                      input logic [1:0] p, input logic rd);
    rst = r; INIZIA = i; MANCHE = m; PARTITA = p; RD_EN = rd;
    @(posedge clk);
    model_step(r, i, m, p, rd);
    #1;
    compare_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_state  = 0;
    m_ovf    = 0;
    foreach (m_rounds[k]) m_rounds[k] = 0;
    foreach (m_games[k])  m_games[k] = 0;
    rst = 1'b1; INIZIA = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00; RD_EN = 1'b0;

    // Reset state
    step(1, 0, 2'b00, 2'b00, 0);
    check("rst_empty", int'(HIST_EMPTY), 1);
    check("rst_game_over", int'(GAME_OVER), 0);

    // Scenario 1
    step(0, 1, 2'b00, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(0, 0, 2'b01, 2'b10, 0);
    check("s1_p1_rounds", int'(P1_ROUNDS), 1);
    check("s1_p2_rounds", int'(P2_ROUNDS), 3);
    check("s1_p2_games", int'(P2_GAMES), 1);
    check("s1_game_over", int'(GAME_OVER), 1);
    check("s1_hist_count", int'(HIST_COUNT), 4);
    begin
      logic [1:0] exp_pop [4];
      exp_pop[0] = 2'b10; exp_pop[1] = 2'b10; exp_pop[2] = 2'b10; exp_pop[3] = 2'b01;
      for (int k = 0; k < 4; k++) begin
        check("s1_pop_data", int'(HIST_DATA), int'(exp_pop[k]));
        step(0, 0, 2'b00, 2'b00, 1);
      end
    end
    check("s1_drained", int'(HIST_EMPTY), 1);

    // Scenario 2
    step(0, 1, 2'b00, 2'b00, 0);
    step(0, 0, 2'b11, 2'b00, 0);
    step(0, 0, 2'b11, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(0, 0, 2'b10, 2'b10, 0);
    check("s2_draws", int'(DRAWS), 2);
    check("s2_p2_rounds", int'(P2_ROUNDS), 2);
    check("s2_p2_games", int'(P2_GAMES), 2);
    step(0, 1, 2'b00, 2'b00, 0);
    check("s2_cleared", int'(DRAWS), 0);
    check("s2_p2_games_held", int'(P2_GAMES), 2);

    // Scenario 3
    step(0, 0, 2'b11, 2'b00, 0);
    step(0, 0, 2'b11, 2'b00, 0);
    step(0, 0, 2'b11, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(0, 0, 2'b01, 2'b11, 0);
    check("s3_tie_games", int'(TIE_GAMES), 1);
    step(0, 0, 2'b01, 2'b00, 0);
    step(0, 0, 2'b01, 2'b01, 0);
    check("s3_ended_hold", int'(P1_ROUNDS), 1);

    // Scenario 4: overflow, then push+pop while full
    step(0, 1, 2'b00, 2'b00, 0);
    for (int k = 0; k < 9; k++) step(0, 0, 2'b01, 2'b00, 0);
    check("s4_full", int'(HIST_FULL), 1);
    check("s4_ovf", int'(HIST_OVF), 1);
    check("s4_p1_rounds", int'(P1_ROUNDS), 9);
    step(0, 0, 2'b10, 2'b00, 1);
    check("s4_count_held", int'(HIST_COUNT), 8);

    // Scenario 5: idle rounds, empty pop, then saturation
    step(0, 1, 2'b00, 2'b00, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 2'b00, 2'b00, 1);
    check("s5_count", int'(HIST_COUNT), 0);
    step(0, 0, 2'b10, 2'b00, 1);
    check("s5_push_on_empty_pop", int'(HIST_COUNT), 1);
    for (int k = 0; k < 16; k++) step(0, 0, 2'b10, 2'b00, 0);
    check("s5_p2_sat", int'(P2_ROUNDS), 15);

    // Mid-game reset discards the game
    step(0, 0, 2'b01, 2'b00, 0);
    step(1, 0, 2'b01, 2'b01, 0);
    check("mid_rst_p1_games", int'(P1_GAMES), 0);

    // Scenario 6: rst wins over INIZIA
    step(0, 1, 2'b00, 2'b00, 0);
    step(0, 0, 2'b10, 2'b00, 0);
    step(1, 1, 2'b01, 2'b00, 0);
    check("s6_count", int'(HIST_COUNT), 0);
    check("s6_game_over", int'(GAME_OVER), 0);
    step(0, 0, 2'b01, 2'b01, 0);
    check("s6_idle_ignores", int'(P1_GAMES), 0);

    // Game tally saturation at 255
    for (int k = 0; k < 260; k++) begin
      step(0, 1, 2'b00, 2'b00, 0);
      step(0, 0, 2'b11, 2'b01, 0);
    end
    check("p1_games_sat", int'(P1_GAMES), 255);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic       r, i, rd;
      logic [1:0] m, p;
      r  = ($urandom_range(0, 99) == 0);
      i  = ($urandom_range(0, 11) == 0);
      m  = 2'($urandom_range(0, 3));
      p  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rd = ($urandom_range(0, 2) == 0);
      step(r, i, m, p, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/morra_scoreboard.md
MORRA_SCOREBOARD -- requirements
Module: morra_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock, rst is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 INIZIA  input  1  game restart strobe, same signal driven into the game FSMD.
REQ-005 MANCHE  input  2  round result from game FSMD: 00 invalid, 01 P1, 10 P2, 11 draw.
REQ-006 PARTITA  input  2  game result from game FSMD: 00 not ended, 01 P1, 10 P2, 11 draw.
REQ-007 RD_EN  input  1  pop request for history FIFO.
REQ-008 P1_ROUNDS, P2_ROUNDS, DRAWS  output  4 each  per-game round tallies.
REQ-009 P1_GAMES, P2_GAMES, TIE_GAMES  output  8 each  cumulative game tallies.
REQ-010 GAME_OVER  output  1  high while state is ENDED.
REQ-011 HIST_DATA  output  2  head of history FIFO (first-word-fall-through), 00 when empty.
REQ-012 HIST_COUNT  output  4  FIFO occupancy, range 0-8.
REQ-013 HIST_EMPTY, HIST_FULL, HIST_OVF  output  1 each  FIFO empty, full, sticky overflow.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, PLAYING, ENDED; GAME_OVER is a registered decode of ENDED.
REQ-015 Inputs SHALL be sampled on each rising clk edge; all outputs are registered and reflect that edge one cycle later, except HIST_DATA/flags, which decode registered FIFO state.
REQ-016 INIZIA=1 in any state SHALL move the FSM to PLAYING and, on the same edge, clear the round tallies, FIFO contents, HIST_COUNT and HIST_OVF; game tallies are retained; MANCHE, PARTITA and RD_EN are ignored that cycle.
REQ-017 In IDLE or ENDED with INIZIA=0, the block SHALL ignore MANCHE and PARTITA and hold all tallies; RD_EN stays functional.
REQ-018 In PLAYING with INIZIA=0, the block SHALL apply these MANCHE actions: 01 increments P1_ROUNDS, 10 increments P2_ROUNDS, 11 increments DRAWS, 00 changes nothing.
REQ-019 Round tallies SHALL saturate at 15 and game tallies at 255, with no wrap.
REQ-020 In PLAYING with INIZIA=0 and PARTITA!=00, the block SHALL take these actions on the same edge as the REQ-018 update: 01 increments P1_GAMES, 10 increments P2_GAMES, 11 increments TIE_GAMES, and the FSM moves to ENDED.
REQ-021 In PLAYING with INIZIA=0 and MANCHE!=00, the block SHALL push MANCHE into the 8-entry history FIFO, including on the game-ending cycle.
REQ-022 A push while full SHALL be dropped (existing contents kept) and SHALL set HIST_OVF, which stays set until rst or INIZIA.
REQ-023 RD_EN=1 with FIFO non-empty SHALL pop one entry; RD_EN while empty SHALL be ignored and SHALL NOT underflow.
REQ-024 Simultaneous push and pop SHALL both occur with HIST_COUNT unchanged, including when full (no overflow) and when empty (the pop is ignored, the push lands, count becomes 1).
REQ-025 HIST_FULL SHALL equal (HIST_COUNT==8) and HIST_EMPTY SHALL equal (HIST_COUNT==0); read/write pointers are 3-bit and wrap modulo 8.

Reset
REQ-026 rst SHALL take priority over INIZIA and all other inputs.
REQ-027 rst SHALL force state IDLE, all tallies 0, HIST_COUNT 0, HIST_DATA 00, HIST_EMPTY 1, HIST_FULL 0, HIST_OVF 0, GAME_OVER 0.
REQ-028 rst asserted mid-game SHALL discard the game in progress with no tally increment, and the next INIZIA starts a fresh game.

Verification
REQ-029 Scenario 1: rst, INIZIA, then MANCHE 10,10,10,01 with PARTITA=10 on the 4th cycle -> P1_ROUNDS=1, P2_ROUNDS=3, P2_GAMES=1, GAME_OVER=1, HIST_COUNT=4, pops yield 10,10,10,01 then HIST_EMPTY=1.
REQ-030 Scenario 2: INIZIA, then MANCHE 11,11,10 and 10 with PARTITA=10 -> DRAWS=2, P2_ROUNDS=2, P2_GAMES increments by 1; next INIZIA -> round tallies 0, P2_GAMES held.
REQ-031 Scenario 3: INIZIA, then MANCHE 11,11,11,10 and 01 with PARTITA=11 -> TIE_GAMES=1; further MANCHE=01 while ENDED -> P1_ROUNDS stays 1.
REQ-032 Scenario 4: INIZIA, then 9 consecutive MANCHE=01, no pops -> HIST_FULL=1, HIST_COUNT=8, HIST_OVF=1, P1_ROUNDS=9; then push+pop on one cycle -> count stays 8.
REQ-033 Scenario 5: INIZIA, MANCHE 00 for 3 cycles, RD_EN=1 while empty -> HIST_COUNT=0, no tally change; then 17 MANCHE=10 -> P2_ROUNDS saturates at 15.
REQ-034 Scenario 6: rst asserted on the same cycle as INIZIA and MANCHE=01 -> state IDLE, all outputs at reset values.
